// File: rtl/rail_seq_ctrl.sv
// Five-rail power sequencer: ramps rails up in order with power-good timeouts,
// ramps them down in reverse, and latches the first failing rail on any fault.
module rail_seq_ctrl #(
  parameter int unsigned PG_TIMEOUT_MS = 100,
  parameter int unsigned STEP_DLY_MS   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cnt1ms_done,
  input  logic       pwr_req,
  input  logic [4:0] rail_pg,
  output logic [4:0] rail_en,
  output logic       all_pwrgd,
  output logic       fault,
  output logic [2:0] fault_step,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_SEQ_UP = 3'd1,
    ST_ON     = 3'd2,
    ST_SEQ_DN = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  localparam logic [7:0] PgTimeout = 8'(PG_TIMEOUT_MS);
  localparam logic [7:0] StepDly   = 8'(STEP_DLY_MS);
  localparam logic [2:0] LastStep  = 3'd4;

  state_e     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [7:0] cnt_q, cnt_d;
  logic       dly_phase_q, dly_phase_d;
  logic [4:0] rail_en_q, rail_en_d;
  logic       all_pwrgd_q, all_pwrgd_d;
  logic       fault_q, fault_d;
  logic [2:0] fault_step_q, fault_step_d;

  logic [7:0] cnt_inc;
  logic [4:0] step_onehot;
  logic [4:0] step_next_onehot;
  logic [4:0] below_mask;
  logic [4:0] up_mask;
  logic [4:0] up_bad;
  logic [4:0] on_bad;
  logic       pg_cur;
  logic       fault_hit;
  logic [2:0] fault_idx;

  function automatic logic [2:0] lowest_set(input logic [4:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [4:0] clear_highest(input logic [4:0] v);
    logic [4:0] r;
    logic       found;
    r     = v;
    found = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      if (!found && v[i]) begin
        r[i]  = 1'b0;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign cnt_inc          = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
  assign step_onehot      = 5'd1 << step_q;
  assign step_next_onehot = 5'd1 << (step_q + 3'd1);
  assign below_mask       = step_onehot - 5'd1;
  assign pg_cur           = (rail_pg & step_onehot) != 5'd0;

  // The rail being waited on only counts as failed once it has reported good.
  assign up_mask = below_mask | (dly_phase_q ? step_onehot : 5'd0);
  assign up_bad  = ~rail_pg & up_mask;
  assign on_bad  = ~rail_pg;

  always_comb begin
    fault_hit = 1'b0;
    fault_idx = 3'd0;
    case (state_q)
      ST_SEQ_UP: begin
        if (up_bad != 5'd0) begin
          fault_hit = 1'b1;
          fault_idx = lowest_set(up_bad);
        end else if (!dly_phase_q && !pg_cur && cnt1ms_done && (cnt_inc >= PgTimeout)) begin
          fault_hit = 1'b1;
          fault_idx = step_q;
        end
      end
      ST_ON: begin
        if (on_bad != 5'd0) begin
          fault_hit = 1'b1;
          fault_idx = lowest_set(on_bad);
        end
      end
      default: begin
        fault_hit = 1'b0;
        fault_idx = 3'd0;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    cnt_d        = cnt_q;
    dly_phase_d  = dly_phase_q;
    rail_en_d    = rail_en_q;
    all_pwrgd_d  = all_pwrgd_q;
    fault_d      = fault_q;
    fault_step_d = fault_step_q;

    if (fault_hit) begin
      state_d      = ST_FAULT;
      rail_en_d    = 5'd0;
      all_pwrgd_d  = 1'b0;
      fault_d      = 1'b1;
      fault_step_d = fault_idx;
      cnt_d        = 8'd0;
      dly_phase_d  = 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          rail_en_d   = 5'd0;
          all_pwrgd_d = 1'b0;
          fault_d     = 1'b0;
          step_d      = 3'd0;
          cnt_d       = 8'd0;
          dly_phase_d = 1'b0;
          if (pwr_req) begin
            state_d   = ST_SEQ_UP;
            rail_en_d = 5'b00001;
          end
        end

        ST_SEQ_UP: begin
          if (!pwr_req) begin
            state_d     = ST_SEQ_DN;
            rail_en_d   = clear_highest(rail_en_q);
            all_pwrgd_d = 1'b0;
            cnt_d       = 8'd0;
            dly_phase_d = 1'b0;
          end else if (!dly_phase_q) begin
            if (pg_cur) begin
              dly_phase_d = 1'b1;
              cnt_d       = 8'd0;
            end else if (cnt1ms_done) begin
              cnt_d = cnt_inc;
            end
          end else if (cnt1ms_done) begin
            if (cnt_inc >= StepDly) begin
              cnt_d       = 8'd0;
              dly_phase_d = 1'b0;
              if (step_q == LastStep) begin
                state_d     = ST_ON;
                rail_en_d   = 5'h1F;
                all_pwrgd_d = 1'b1;
              end else begin
                step_d    = step_q + 3'd1;
                rail_en_d = rail_en_q | step_next_onehot;
              end
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end

        ST_ON: begin
          rail_en_d   = 5'h1F;
          all_pwrgd_d = 1'b1;
          if (!pwr_req) begin
            state_d     = ST_SEQ_DN;
            rail_en_d   = clear_highest(rail_en_q);
            all_pwrgd_d = 1'b0;
            cnt_d       = 8'd0;
          end
        end

        // Power-down always runs to completion; a new request is seen from OFF.
        ST_SEQ_DN: begin
          all_pwrgd_d = 1'b0;
          if (rail_en_q == 5'd0) begin
            state_d     = ST_OFF;
            step_d      = 3'd0;
            cnt_d       = 8'd0;
            dly_phase_d = 1'b0;
          end else if (cnt1ms_done) begin
            if (cnt_inc >= StepDly) begin
              rail_en_d = clear_highest(rail_en_q);
              cnt_d     = 8'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end

        ST_FAULT: begin
          rail_en_d   = 5'd0;
          all_pwrgd_d = 1'b0;
          fault_d     = 1'b1;
          if (!pwr_req) begin
            state_d     = ST_OFF;
            fault_d     = 1'b0;
            step_d      = 3'd0;
            cnt_d       = 8'd0;
            dly_phase_d = 1'b0;
          end
        end

        default: begin
          state_d     = ST_OFF;
          rail_en_d   = 5'd0;
          all_pwrgd_d = 1'b0;
          fault_d     = 1'b0;
          step_d      = 3'd0;
          cnt_d       = 8'd0;
          dly_phase_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_OFF;
      step_q       <= 3'd0;
      cnt_q        <= 8'd0;
      dly_phase_q  <= 1'b0;
      rail_en_q    <= 5'd0;
      all_pwrgd_q  <= 1'b0;
      fault_q      <= 1'b0;
      fault_step_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      dly_phase_q  <= dly_phase_d;
      rail_en_q    <= rail_en_d;
      all_pwrgd_q  <= all_pwrgd_d;
      fault_q      <= fault_d;
      fault_step_q <= fault_step_d;
    end
  end

  assign rail_en    = rail_en_q;
  assign all_pwrgd  = all_pwrgd_q;
  assign fault      = fault_q;
  assign fault_step = fault_step_q;
  assign seq_state  = state_q;

endmodule

// File: doc/rail_seq_ctrl.md
RAIL_SEQ_CTRL -- requirements
Module: rail_seq_ctrl

Interface
REQ-001 Parameter PG_TIMEOUT_MS, default 100: ms ticks allowed for a rail's power-good after its enable, range 1..255.
REQ-002 Parameter STEP_DLY_MS, default 2: ms ticks between a rail's power-good and the next step, range 1..255.
REQ-003 clk  input  1  system clock; the single clock domain.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cnt1ms_done  input  1  one-cycle pulse every 1 ms; the only time base.
REQ-006 pwr_req  input  1  level power-on request, synchronous to clk.
REQ-007 rail_pg  input  5  power-good per step: [0] PSU pwrok, [1] P1V5, [2] P1V05, [3] VPP/VDDQ (ab & cd), [4] VCCIN CPU0.
REQ-008 rail_en  output  5  enable per step, same index map as rail_pg; registered.
REQ-009 all_pwrgd  output  1  high only in ON; registered.
REQ-010 fault  output  1  high only in FAULT; registered.
REQ-011 fault_step  output  3  step index of the first detected fault, 0..4; registered.
REQ-012 seq_state  output  3  encoded state: OFF=0, SEQ_UP=1, ON=2, SEQ_DN=3, FAULT=4.

Function
REQ-013 States OFF, SEQ_UP, ON, SEQ_DN, FAULT; internal step index (3 bits), 8-bit tick counter; counter cleared on every state or step change.
REQ-014 OFF: rail_en=0. pwr_req=1 -> SEQ_UP with step=0; rail_en[0] set on that same edge (1-cycle latency from pwr_req sampled high).
REQ-015 SEQ_UP wait phase: counter increments on cnt1ms_done while rail_pg[step]=0; counter reaching PG_TIMEOUT_MS -> FAULT, fault_step=step.
REQ-016 SEQ_UP: on first cycle rail_pg[step]=1, counter clears and the delay phase starts; counter increments on cnt1ms_done.
REQ-017 Delay phase: counter reaching STEP_DLY_MS -> step+1 and rail_en[step+1] set on the same edge; when step=4 the transition goes to ON instead.
REQ-018 SEQ_UP: any rail_pg[i]=0 with i<step, or with i=step during the delay phase -> FAULT, fault_step=i (lowest such i).
REQ-019 ON: rail_en=5'h1F, all_pwrgd=1; any rail_pg bit 0 -> FAULT, fault_step=lowest dropped index.
REQ-020 pwr_req=0 in SEQ_UP or ON -> SEQ_DN; all_pwrgd clears on that edge.
REQ-021 SEQ_DN: clear the highest set rail_en bit immediately on entry, then clear one more bit (descending) each time the counter reaches STEP_DLY_MS; rail_pg is ignored. rail_en=0 -> OFF.
REQ-022 SEQ_DN: pwr_req=1 does not abort; the sequence completes to OFF, and the next cycle re-evaluates pwr_req.
REQ-023 FAULT: rail_en cleared to 0 on the entry edge (all rails simultaneously), fault=1; fault_step is held.
REQ-024 FAULT exit only via pwr_req=0 sampled -> OFF, fault cleared; fault_step is held until the next fault or reset.
REQ-025 Priority on the same cycle: fault condition > pwr_req=0 > step advance.
REQ-026 Tick counter saturates at 255; no wrap.

Reset
REQ-027 rst_n=0 asynchronously forces OFF, rail_en=0, all_pwrgd=0, fault=0, fault_step=0, seq_state=0, step=0, counter=0, including mid-sequence.
REQ-028 The first transition after reset release occurs on the first rising clk with rst_n=1.

Verification
REQ-029 Nominal: pwr_req=1; each rail_pg rises 3 ticks after its enable -> rail_en steps 1,3,7,F,1F, each 2 ticks after the preceding pg; all_pwrgd=1; seq_state=2.
REQ-030 Timeout: rail_pg[2] held 0 -> exactly 100 ticks after rail_en[2] fault=1, fault_step=2, rail_en=0; pwr_req=0 -> seq_state=0, fault=0.
REQ-031 Droop in ON: drop rail_pg[3] for 1 cycle -> next edge fault=1, fault_step=3, rail_en=0, all_pwrgd=0.
REQ-032 Power-down: ON, pwr_req=0 -> rail_en 0F immediately, then 07, 03, 01, 00 at 2-tick intervals -> OFF.
REQ-033 Simultaneous: in ON, pwr_req=0 and rail_pg[1]=0 on the same cycle -> FAULT (fault_step=1), not SEQ_DN.
REQ-034 Reset mid-op: rst_n=0 during SEQ_UP step 3 -> rail_en=0 and seq_state=0 without a clock edge; release with pwr_req=1 -> restart at step 0.
